// File: rtl/streamer_pkg.sv
// ---------------------------------------------------------------------------
// streamer_pkg
// Shared definitions for the BRAM readback streamer:
//   state_e     - controller states (IDLE, HDR, READ, DRAIN)
//   HDR_WORD_W  - width of one header word before zero extension
//   SKID_DEPTH  - number of entries in the output skid buffer
// ---------------------------------------------------------------------------
package streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    READ,
    DRAIN
  } state_e;

  localparam int HDR_WORD_W = 16;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry output buffer for an AXI-Stream master. The producer never sees a
// ready signal; it tracks free space through count_o and only pushes when an
// entry is guaranteed to be available. Payload is tdata plus tlast.
// Ports:
//   aclk, aresetn            - clock, asynchronous active-low reset
//   push_i, pushData_i,
//   pushLast_i               - write one beat into the buffer
//   tdata_o, tvalid_o,
//   tready_i, tlast_o        - AXI-Stream master side
//   count_o                  - number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module axis_skid_buffer
  import streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 20
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] pushData_i,
  input  logic                  pushLast_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH:0] entry_q [SKID_DEPTH];
  logic                wrPtr_q;
  logic                rdPtr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic                pop;

  // A beat leaves whenever the head entry is presented and the sink accepts
  // it; occupancy moves by the difference of push and pop in the same cycle.
  always_comb begin
    pop     = (count_q != 2'd0) && tready_i;
    count_d = count_q + {1'b0, push_i} - {1'b0, pop};
  end

  // Ring of two entries. Contents only change on a push into the slot the
  // write pointer names, so the head entry stays frozen while the sink stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        entry_q[wrPtr_q] <= {pushLast_i, pushData_i};
        wrPtr_q          <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

  // Outputs are forced to zero while empty so an idle bus shows no stale beat.
  always_comb begin
    tvalid_o = (count_q != 2'd0);
    tdata_o  = tvalid_o ? entry_q[rdPtr_q][DATA_WIDTH-1:0] : '0;
    tlast_o  = tvalid_o ? entry_q[rdPtr_q][DATA_WIDTH] : 1'b0;
    count_o  = count_q;
  end

endmodule

// File: rtl/axis_readback_streamer.sv
// ---------------------------------------------------------------------------
// axis_readback_streamer
// Streams a header followed by the contents of a range of BRAM banks over
// AXI-Stream. Header words and BRAM reads travel through one common pipeline
// so ordering is preserved and there is no gap between header and data.
// Optional feature (macro STREAMER_RELU_EN): data beats with the sign bit set
// are replaced by zero in an extra registered stage; header beats never are.
// Ports:
//   aclk, aresetn                     - clock, asynchronous active-low reset
//   start, notify_only                - job request, header-only flag
//   bank_start, bank_end              - inclusive bank range
//   addr_start, addr_count            - per-bank start address and length
//   header_flat                       - header words, word 0 in bits [15:0]
//   bram_rd_addr, bram_rd_en          - shared BRAM read port (1-cycle latency)
//   bram_rd_data_flat                 - read data, bank k in slice k
//   m_axis_tdata/tvalid/tready/tlast  - AXI-Stream master
//   busy, done                        - job active, one-cycle completion pulse
// ---------------------------------------------------------------------------
module axis_readback_streamer
  import streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int NUM_BANKS  = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int HDR_WORDS  = 6
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            start,
  input  logic                            notify_only,
  input  logic [$clog2(NUM_BANKS)-1:0]    bank_start,
  input  logic [$clog2(NUM_BANKS)-1:0]    bank_end,
  input  logic [ADDR_WIDTH-1:0]           addr_start,
  input  logic [ADDR_WIDTH:0]             addr_count,
  input  logic [HDR_WORDS*HDR_WORD_W-1:0] header_flat,
  output logic [ADDR_WIDTH-1:0]           bram_rd_addr,
  output logic                            bram_rd_en,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bram_rd_data_flat,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            busy,
  output logic                            done
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int HIDX_W = $clog2(HDR_WORDS + 1);
  localparam logic [HIDX_W-1:0] HDR_LAST = HIDX_W'(HDR_WORDS - 1);
  localparam logic [HIDX_W-1:0] HDR_END  = HIDX_W'(HDR_WORDS);
`ifdef STREAMER_RELU_EN
  localparam int CREDITS = SKID_DEPTH + 1;
`else
  localparam int CREDITS = SKID_DEPTH;
`endif

  state_e                          state_q;
  logic                            hdrOnly_q;
  logic [BANK_W-1:0]               bankEnd_q;
  logic [BANK_W-1:0]               bank_q;
  logic [ADDR_WIDTH-1:0]           addrStart_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [ADDR_WIDTH:0]             addrCount_q;
  logic [ADDR_WIDTH:0]             remaining_q;
  logic [HDR_WORDS*HDR_WORD_W-1:0] header_q;
  logic [HIDX_W-1:0]               hdrIdx_q;
  logic                            busy_q;
  logic                            done_q;

  logic                            s1Valid_q;
  logic                            s1IsHdr_q;
  logic                            s1Last_q;
  logic [HDR_WORD_W-1:0]           s1Hdr_q;
  logic [BANK_W-1:0]               s1Bank_q;
  logic [DATA_WIDTH-1:0]           s1Data;

  logic                            pushValid;
  logic [DATA_WIDTH-1:0]           pushData;
  logic                            pushLast;
  logic [1:0]                      skidCount;
  logic [2:0]                      used;
  logic                            pop;
  logic                            finalBeat;
  logic                            canIssue;
  logic                            hdrIssue;
  logic                            rdIssue;
  logic                            lastHdr;
  logic                            lastRead;
  logic [HDR_WORD_W-1:0]           hdrWord;

`ifdef STREAMER_RELU_EN
  logic                            r2Valid_q;
  logic                            r2Last_q;
  logic [DATA_WIDTH-1:0]           r2Data_q;
  logic                            skidRoom;

  // The clamp stage is elastic: it holds its beat while the skid buffer is
  // full, which makes it a third storage slot and keeps full throughput.
  always_comb begin
    skidRoom  = (skidCount != 2'(SKID_DEPTH)) || pop;
    pushValid = r2Valid_q && skidRoom;
    pushData  = r2Data_q;
    pushLast  = r2Last_q;
    used      = {1'b0, skidCount} + {2'b00, s1Valid_q} + {2'b00, r2Valid_q};
  end

  // Negative data words become zero; header words pass through untouched.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r2Valid_q <= 1'b0;
      r2Last_q  <= 1'b0;
      r2Data_q  <= '0;
    end else if (!r2Valid_q || skidRoom) begin
      r2Valid_q <= s1Valid_q;
      r2Last_q  <= s1Last_q;
      r2Data_q  <= (!s1IsHdr_q && s1Data[DATA_WIDTH-1]) ? '0 : s1Data;
    end
  end
`else
  // Without the clamp stage the returning word goes straight into the buffer.
  always_comb begin
    pushValid = s1Valid_q;
    pushData  = s1Data;
    pushLast  = s1Last_q;
    used      = {1'b0, skidCount} + {2'b00, s1Valid_q};
  end
`endif

  // Credit check: a new word may only be launched when every word already in
  // the pipeline plus this one fits in the buffering, counting the beat the
  // sink takes this cycle. This is what makes dropping a word impossible.
  always_comb begin
    pop       = m_axis_tvalid && m_axis_tready;
    finalBeat = pop && m_axis_tlast;
    canIssue  = used < (3'(CREDITS) + {2'b00, pop});
    hdrIssue  = (state_q == HDR) && (hdrIdx_q != HDR_END) && canIssue;
    rdIssue   = (state_q == READ) && canIssue;
    lastHdr   = (hdrIdx_q == HDR_LAST);
    lastRead  = (bank_q == bankEnd_q) && (remaining_q == (ADDR_WIDTH+1)'(1));
    hdrWord   = header_q[int'(hdrIdx_q)*HDR_WORD_W +: HDR_WORD_W];
    s1Data    = s1IsHdr_q ? DATA_WIDTH'(s1Hdr_q)
                          : bram_rd_data_flat[int'(s1Bank_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Controller. Job parameters are captured on an accepted start. The header
  // phase ends in IDLE for header-only jobs once the tlast beat is taken;
  // otherwise reads walk the bank range and DRAIN waits for the final beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      hdrOnly_q   <= 1'b0;
      bankEnd_q   <= '0;
      bank_q      <= '0;
      addrStart_q <= '0;
      addr_q      <= '0;
      addrCount_q <= '0;
      remaining_q <= '0;
      header_q    <= '0;
      hdrIdx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finalBeat;
      case (state_q)
        IDLE: begin
          if (start) begin
            hdrOnly_q   <= notify_only || (addr_count == '0) || (bank_end < bank_start);
            bankEnd_q   <= bank_end;
            bank_q      <= bank_start;
            addrStart_q <= addr_start;
            addr_q      <= addr_start;
            addrCount_q <= addr_count;
            remaining_q <= addr_count;
            header_q    <= header_flat;
            hdrIdx_q    <= '0;
            busy_q      <= 1'b1;
            state_q     <= HDR;
          end
        end
        HDR: begin
          if (hdrIssue) begin
            hdrIdx_q <= hdrIdx_q + 1'b1;
            if (lastHdr && !hdrOnly_q) begin
              state_q <= READ;
            end
          end
          if (finalBeat) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        READ: begin
          if (rdIssue) begin
            if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
              bank_q      <= bank_q + 1'b1;
              addr_q      <= addrStart_q;
              remaining_q <= addrCount_q;
            end else begin
              addr_q      <= addr_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
            end
            if (lastRead) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (finalBeat) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // First pipeline stage: marks the cycle in which the BRAM answer (or the
  // header word launched alongside it) is available, and which bank to pick.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1Valid_q <= 1'b0;
      s1IsHdr_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1Hdr_q   <= '0;
      s1Bank_q  <= '0;
    end else begin
      s1Valid_q <= hdrIssue || rdIssue;
      s1IsHdr_q <= hdrIssue;
      s1Last_q  <= (hdrIssue && lastHdr && hdrOnly_q) || (rdIssue && lastRead);
      s1Bank_q  <= bank_q;
      if (hdrIssue) begin
        s1Hdr_q <= hdrWord;
      end
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) uSkid (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push_i     (pushValid),
    .pushData_i (pushData),
    .pushLast_i (pushLast),
    .tdata_o    (m_axis_tdata),
    .tvalid_o   (m_axis_tvalid),
    .tready_i   (m_axis_tready),
    .tlast_o    (m_axis_tlast),
    .count_o    (skidCount)
  );

  // The read strobe is a credit-gated decode so a read can follow a pop in the
  // same cycle; address and status flags come straight from registers.
  always_comb begin
    bram_rd_en   = rdIssue;
    bram_rd_addr = addr_q;
    busy         = busy_q;
    done         = done_q;
  end

endmodule

// File: tb/tb_axis_readback_streamer.sv
// ---------------------------------------------------------------------------
// tb_axis_readback_streamer
// Directed bench for axis_readback_streamer: notify job, full two-bank job,
// the same under random backpressure, address wrap, empty jobs, reset abort,
// and the sign clamp when STREAMER_RELU_EN is defined.
// ---------------------------------------------------------------------------
module tb_axis_readback_streamer;

  localparam int DW = 20;
  localparam int NB = 16;
  localparam int AW = 9;
  localparam int HW = 6;
  localparam int BW = 4;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start;
  logic              notify_only;
  logic [BW-1:0]     bank_start;
  logic [BW-1:0]     bank_end;
  logic [AW-1:0]     addr_start;
  logic [AW:0]       addr_count;
  logic [HW*16-1:0]  header_flat;
  logic [AW-1:0]     bram_rd_addr;
  logic              bram_rd_en;
  logic [NB*DW-1:0]  bram_rd_data_flat = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;

  int checkCount = 0;
  int errorCount = 0;

  logic [DW-1:0] obsData[$];
  logic          obsLast[$];
  int            obsAddr[$];
  logic [DW-1:0] expData[$];
  logic          expLast[$];
  int            expAddr[$];
  int            doneCount;
  int            doneCyc;
  int            firstBeatCyc;
  int            lastBeatCyc;
  int            stallErrs;

  axis_readback_streamer #(
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB),
    .ADDR_WIDTH (AW),
    .HDR_WORDS  (HW)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .notify_only       (notify_only),
    .bank_start        (bank_start),
    .bank_end          (bank_end),
    .addr_start        (addr_start),
    .addr_count        (addr_count),
    .header_flat       (header_flat),
    .bram_rd_addr      (bram_rd_addr),
    .bram_rd_en        (bram_rd_en),
    .bram_rd_data_flat (bram_rd_data_flat),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .busy              (busy),
    .done              (done)
  );

  // Free-running 100 MHz clock.
  always #5 aclk = ~aclk;

  // Memory contents: bank*0x100 + addr, with two sign-test words in bank 5
  // when the clamp feature is built in.
  function automatic logic [DW-1:0] bramWord(input int bank, input int addr);
`ifdef STREAMER_RELU_EN
    if (bank == 5) begin
      return (addr == 0) ? 20'hFFFFF : 20'h7FFFF;
    end
`endif
    return DW'(bank * 256 + addr);
  endfunction

  // BRAM model: every bank answers the shared address one cycle after the strobe.
  always @(posedge aclk) begin
    if (bram_rd_en) begin
      for (int k = 0; k < NB; k++) begin
        bram_rd_data_flat[k*DW +: DW] <= bramWord(k, int'(bram_rd_addr));
      end
    end
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beat and address sequence for one job.
  task automatic buildExpect(input logic notify, input int bs, input int be, input int as,
                             input int cnt, input int hdrBase);
    logic          hdrOnly;
    logic [DW-1:0] w;
    int            a;
    expData.delete();
    expLast.delete();
    expAddr.delete();
    hdrOnly = notify || (cnt == 0) || (be < bs);
    for (int i = 0; i < HW; i++) begin
      expData.push_back(DW'(hdrBase + i));
      expLast.push_back(hdrOnly && (i == HW - 1));
    end
    if (!hdrOnly) begin
      for (int b = bs; b <= be; b++) begin
        for (int j = 0; j < cnt; j++) begin
          a = (as + j) % 512;
          w = bramWord(b, a);
`ifdef STREAMER_RELU_EN
          if (w[DW-1]) w = '0;
`endif
          expData.push_back(w);
          expLast.push_back((b == be) && (j == cnt - 1));
          expAddr.push_back(a);
        end
      end
    end
  endtask

  // Runs one job: pulses start, scrambles the inputs afterwards, re-pulses
  // start while busy, drives tready at readyPct percent and records beats,
  // reads and done pulses. abortBeats > 0 stops after that many beats.
  task automatic applyStimulus(input string name, input logic notify, input int bs, input int be,
                               input int as, input int cnt, input int hdrBase,
                               input int readyPct, input int abortBeats);
    logic          prevStalled;
    logic [DW-1:0] prevData;
    logic          prevLast;
    int            tail;
    buildExpect(notify, bs, be, as, cnt, hdrBase);
    obsData.delete();
    obsLast.delete();
    obsAddr.delete();
    doneCount    = 0;
    doneCyc      = -1;
    firstBeatCyc = -1;
    lastBeatCyc  = -1;
    stallErrs    = 0;
    prevStalled  = 1'b0;
    prevData     = '0;
    prevLast     = 1'b0;
    tail         = 0;
    @(negedge aclk);
    notify_only = notify;
    bank_start  = BW'(bs);
    bank_end    = BW'(be);
    addr_start  = AW'(as);
    addr_count  = (AW+1)'(cnt);
    for (int i = 0; i < HW; i++) begin
      header_flat[i*16 +: 16] = 16'(hdrBase + i);
    end
    start = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    notify_only = ~notify;
    bank_start  = '0;
    bank_end    = '1;
    addr_start  = 9'h055;
    addr_count  = 10'd7;
    header_flat = '1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      start = (cyc == 2);
      m_axis_tready = (int'($urandom_range(99, 0)) < readyPct);
      #1;
      if (cyc == 0) checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
      if (prevStalled && (!m_axis_tvalid || m_axis_tdata !== prevData || m_axis_tlast !== prevLast)) begin
        stallErrs++;
      end
      prevStalled = m_axis_tvalid && !m_axis_tready;
      prevData    = m_axis_tdata;
      prevLast    = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        obsData.push_back(m_axis_tdata);
        obsLast.push_back(m_axis_tlast);
        if (firstBeatCyc < 0) firstBeatCyc = cyc;
        lastBeatCyc = cyc;
      end
      if (bram_rd_en) obsAddr.push_back(int'(bram_rd_addr));
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (doneCount > 0) tail++;
      if (tail > 4) break;
      if (abortBeats > 0 && obsData.size() >= abortBeats) break;
      @(negedge aclk);
    end
    start = 1'b0;
    if (abortBeats == 0) begin
      checkOutput({name, " beat count"}, 32'(obsData.size()), 32'(expData.size()));
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
        checkOutput($sformatf("%s beat%0d tdata", name, i), 32'(obsData[i]), 32'(expData[i]));
        checkOutput($sformatf("%s beat%0d tlast", name, i), 32'(obsLast[i]), 32'(expLast[i]));
      end
      checkOutput({name, " read count"}, 32'(obsAddr.size()), 32'(expAddr.size()));
      for (int i = 0; i < obsAddr.size() && i < expAddr.size(); i++) begin
        checkOutput($sformatf("%s read%0d addr", name, i), 32'(obsAddr[i]), 32'(expAddr[i]));
      end
      checkOutput({name, " done pulses"}, 32'(doneCount), 32'd1);
      checkOutput({name, " done timing"}, 32'(doneCyc - lastBeatCyc), 32'd1);
      checkOutput({name, " stall stability"}, 32'(stallErrs), 32'd0);
      if (readyPct == 100) begin
        checkOutput({name, " throughput"}, 32'(lastBeatCyc - firstBeatCyc), 32'(expData.size() - 1));
      end
      checkOutput({name, " busy at end"}, 32'(busy), 32'd0);
    end
  endtask

  // Checks every output against its reset value.
  task automatic checkResetState(input string name);
    checkOutput({name, " tvalid"}, 32'(m_axis_tvalid), 32'd0);
    checkOutput({name, " tlast"}, 32'(m_axis_tlast), 32'd0);
    checkOutput({name, " tdata"}, 32'(m_axis_tdata), 32'd0);
    checkOutput({name, " rd_en"}, 32'(bram_rd_en), 32'd0);
    checkOutput({name, " rd_addr"}, 32'(bram_rd_addr), 32'd0);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " done"}, 32'(done), 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence of directed jobs.
  initial begin
    aresetn       = 1'b0;
    start         = 1'b0;
    notify_only   = 1'b0;
    bank_start    = '0;
    bank_end      = '0;
    addr_start    = '0;
    addr_count    = '0;
    header_flat   = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    checkResetState("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    applyStimulus("notify", 1'b1, 0, 0, 0, 4, 'hA001, 100, 0);
    applyStimulus("full", 1'b0, 2, 3, 0, 4, 'hB001, 100, 0);
    applyStimulus("backpressure", 1'b0, 2, 3, 0, 4, 'hB001, 30, 0);
    applyStimulus("wrap", 1'b0, 7, 7, 510, 4, 'h1001, 100, 0);
    applyStimulus("empty count", 1'b0, 1, 4, 0, 0, 'h2001, 100, 0);
    applyStimulus("empty range", 1'b0, 5, 2, 0, 3, 'h3001, 70, 0);
`ifdef STREAMER_RELU_EN
    applyStimulus("relu", 1'b0, 5, 5, 0, 2, 'h8000, 100, 0);
`endif

    applyStimulus("abort", 1'b0, 2, 3, 0, 4, 'hC001, 100, 9);
    checkOutput("abort beats reached", 32'(obsData.size()), 32'd9);
    if (obsData.size() >= 9) checkOutput("abort third data beat", 32'(obsData[8]), 32'h202);
    aresetn = 1'b0;
    #1;
    checkResetState("abort reset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    applyStimulus("post-abort notify", 1'b1, 0, 0, 0, 0, 'hD001, 100, 0);

    repeat (3) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
